// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment display capture block:
// the hex glyph set (active-low, bit 6 = A .. bit 0 = G), the scanner
// state encoding and the dwell-length helper.
package seven_segment_pkg;

    localparam int unsigned SEG_W = 7;

    // Active-low glyphs; a 0 bit lights the segment.
    localparam logic [SEG_W-1:0] GLYPH_0 = 7'b0000001;
    localparam logic [SEG_W-1:0] GLYPH_1 = 7'b1001111;
    localparam logic [SEG_W-1:0] GLYPH_2 = 7'b0010010;
    localparam logic [SEG_W-1:0] GLYPH_3 = 7'b0000110;
    localparam logic [SEG_W-1:0] GLYPH_4 = 7'b1001100;
    localparam logic [SEG_W-1:0] GLYPH_5 = 7'b0100100;
    localparam logic [SEG_W-1:0] GLYPH_6 = 7'b0100000;
    localparam logic [SEG_W-1:0] GLYPH_7 = 7'b0001111;
    localparam logic [SEG_W-1:0] GLYPH_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] GLYPH_9 = 7'b0000100;
    localparam logic [SEG_W-1:0] GLYPH_A = 7'b0001000;
    localparam logic [SEG_W-1:0] GLYPH_B = 7'b1100000;
    localparam logic [SEG_W-1:0] GLYPH_C = 7'b0110001;
    localparam logic [SEG_W-1:0] GLYPH_D = 7'b1000010;
    localparam logic [SEG_W-1:0] GLYPH_E = 7'b0110000;
    localparam logic [SEG_W-1:0] GLYPH_F = 7'b0111000;

    // Index n holds the glyph for hex value n.
    localparam logic [15:0][SEG_W-1:0] GLYPH_TABLE = {
        GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
        GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // Expected per-digit dwell in clock cycles.
    function automatic int unsigned dwell_clocks(input int unsigned clk_hz,
                                                 input int unsigned dwell_us);
        return clk_hz / 32'd1_000_000 * dwell_us;
    endfunction

endpackage

// File: rtl/seven_segment_decode.sv
// Combinational glyph decoder: active-low segment pattern to hex nibble.
// Patterns outside the 16 hex glyphs decode to 0 with bad raised.
module seven_segment_decode
    import seven_segment_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] hex,
    output logic       bad
);

    // Table match; glyphs are unique so at most one entry hits.
    always_comb begin
        hex = 4'h0;
        bad = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (pattern == GLYPH_TABLE[i]) begin
                hex = 4'(i);
                bad = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seven_segment_capture.sv
// Passive capture of a multiplexed seven-segment display bus into whole
// decoded frames. A frame is handed out when every digit has been seen and
// the anode pattern next changes. Optional dwell-time checking is built
// only when SEVEN_SEGMENT_DWELL_CHECK_EN is defined; otherwise err_dwell is 0.
module seven_segment_capture
    import seven_segment_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 8,
    parameter int unsigned CLK_FREQUENCY = 100_000_000,
    parameter int unsigned DWELL_US      = 1000,
    parameter int unsigned DWELL_TOL     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              segments,
    input  logic                    dp_out,
    input  logic [NUM_DIGITS-1:0]   an_out,
    input  logic                    frame_ready,
    input  logic                    err_clear,
    output logic                    frame_valid,
    output logic [4*NUM_DIGITS-1:0] frame_value,
    output logic [NUM_DIGITS-1:0]   frame_dp,
    output logic [NUM_DIGITS-1:0]   frame_bad,
    output logic                    err_multi_anode,
    output logic                    err_dwell,
    output logic                    err_overrun
);

    localparam int unsigned DWELL_CLOCKS = dwell_clocks(CLK_FREQUENCY, DWELL_US);

    // Reject unusable configurations at elaboration.
    if (NUM_DIGITS < 1 || NUM_DIGITS > 16 || DWELL_TOL >= DWELL_CLOCKS) begin : g_bad_cfg
        $error("seven_segment_capture: unsupported NUM_DIGITS or dwell configuration");
    end

    state_t                  state;
    state_t                  state_next;
    logic [NUM_DIGITS-1:0]   an_out_d;
    logic [NUM_DIGITS-1:0]   collected;
    logic [4*NUM_DIGITS-1:0] work_value;
    logic [NUM_DIGITS-1:0]   work_dp;
    logic [NUM_DIGITS-1:0]   work_bad;

    logic [NUM_DIGITS-1:0]   an_low_c;
    logic                    one_low_c;
    logic                    multi_c;
    logic                    changed_c;
    logic                    in_scan_c;
    logic                    complete_c;
    logic                    deliver_c;
    logic                    overrun_c;
    logic [3:0]              dec_hex;
    logic                    dec_bad;

    seven_segment_decode u_decode (
        .pattern (segments),
        .hex     (dec_hex),
        .bad     (dec_bad)
    );

    // Anode classification and frame hand-off conditions.
    always_comb begin
        an_low_c   = ~an_out;
        one_low_c  = (an_low_c != '0) &&
                     ((an_low_c & (an_low_c - NUM_DIGITS'(1))) == '0);
        multi_c    = (an_low_c != '0) && !one_low_c;
        changed_c  = (an_out != an_out_d);
        in_scan_c  = (state == ST_SCAN);
        complete_c = in_scan_c && changed_c && (&collected);
        deliver_c  = complete_c && (!frame_valid || frame_ready);
        overrun_c  = complete_c && frame_valid && !frame_ready;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Leave IDLE on the first single-digit cycle; SCAN persists until reset.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (one_low_c) state_next = ST_SCAN;
            ST_SCAN: state_next = ST_SCAN;
            default: state_next = ST_IDLE;
        endcase
    end

    // Previous anode pattern for change detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_out_d <= '1;
        end else begin
            an_out_d <= an_out;
        end
    end

    // Digits seen in the current frame; a completion restarts it with the digit sampled now.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            collected <= '0;
        end else if (complete_c) begin
            collected <= one_low_c ? an_low_c : '0;
        end else if (one_low_c) begin
            collected <= collected | an_low_c;
        end
    end

    // Working copy of the decoded digits, updated only on single-digit cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_value <= '0;
            work_dp    <= '0;
            work_bad   <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (one_low_c && an_low_c[i]) begin
                    work_value[4*i +: 4] <= dec_hex;
                    work_dp[i]           <= dp_out;
                    work_bad[i]          <= dec_bad;
                end
            end
        end
    end

    // Output frame with valid/ready hold; a completion during a stall is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_valid <= 1'b0;
            frame_value <= '0;
            frame_dp    <= '0;
            frame_bad   <= '0;
        end else if (deliver_c) begin
            frame_valid <= 1'b1;
            frame_value <= work_value;
            frame_dp    <= work_dp;
            frame_bad   <= work_bad;
        end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

    // Sticky anode and overrun errors; a set wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_multi_anode <= 1'b0;
            err_overrun     <= 1'b0;
        end else begin
            err_multi_anode <= (err_multi_anode && !err_clear) || multi_c;
            err_overrun     <= (err_overrun && !err_clear) || overrun_c;
        end
    end

`ifdef SEVEN_SEGMENT_DWELL_CHECK_EN
    localparam int unsigned DWELL_LO = DWELL_CLOCKS - DWELL_TOL;
    localparam int unsigned DWELL_HI = DWELL_CLOCKS + DWELL_TOL;
    localparam int unsigned CNT_W    = $clog2(DWELL_HI + 2) + 1;

    logic [CNT_W-1:0] dwell_cnt;
    logic             exempt;
    logic [CNT_W:0]   held_c;
    logic             dwell_bad_c;

    // Cycles the outgoing pattern was on the bus, including its first cycle.
    always_comb begin
        held_c      = {1'b0, dwell_cnt} + (CNT_W+1)'(1);
        dwell_bad_c = in_scan_c && changed_c && !exempt &&
                      ((held_c < (CNT_W+1)'(DWELL_LO)) || (held_c > (CNT_W+1)'(DWELL_HI)));
    end

    // Saturating dwell counter; the first change in SCAN ends a partial dwell and is not judged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_cnt <= '0;
            exempt    <= 1'b1;
        end else if (!in_scan_c) begin
            dwell_cnt <= '0;
            exempt    <= 1'b1;
        end else if (changed_c) begin
            dwell_cnt <= '0;
            exempt    <= 1'b0;
        end else if (dwell_cnt != '1) begin
            dwell_cnt <= dwell_cnt + CNT_W'(1);
        end
    end

    // Sticky dwell error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_dwell <= 1'b0;
        end else begin
            err_dwell <= (err_dwell && !err_clear) || dwell_bad_c;
        end
    end
`else
    assign err_dwell = 1'b0;
`endif

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture (8 digits, 100-clock dwell, tolerance 2).
// Expected err_dwell follows SEVEN_SEGMENT_DWELL_CHECK_EN.
module tb_seven_segment_capture;

`ifdef SEVEN_SEGMENT_DWELL_CHECK_EN
    localparam logic DWELL_EN = 1'b1;
`else
    localparam logic DWELL_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [6:0]  segments;
    logic        dp_out;
    logic [7:0]  an_out;
    logic        frame_ready;
    logic        err_clear;
    logic        frame_valid;
    logic [31:0] frame_value;
    logic [7:0]  frame_dp;
    logic [7:0]  frame_bad;
    logic        err_multi_anode;
    logic        err_dwell;
    logic        err_overrun;

    int tests;
    int fails;

    seven_segment_capture #(
        .NUM_DIGITS    (8),
        .CLK_FREQUENCY (100_000_000),
        .DWELL_US      (1),
        .DWELL_TOL     (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .segments        (segments),
        .dp_out          (dp_out),
        .an_out          (an_out),
        .frame_ready     (frame_ready),
        .err_clear       (err_clear),
        .frame_valid     (frame_valid),
        .frame_value     (frame_value),
        .frame_dp        (frame_dp),
        .frame_bad       (frame_bad),
        .err_multi_anode (err_multi_anode),
        .err_dwell       (err_dwell),
        .err_overrun     (err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-low glyph, written as the inverse of the lit segments (A..G).
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] lit;
        case (n)
            4'h0: lit = 7'b1111110;
            4'h1: lit = 7'b0110000;
            4'h2: lit = 7'b1101101;
            4'h3: lit = 7'b1111001;
            4'h4: lit = 7'b0110011;
            4'h5: lit = 7'b1011011;
            4'h6: lit = 7'b1011111;
            4'h7: lit = 7'b1110000;
            4'h8: lit = 7'b1111111;
            4'h9: lit = 7'b1111011;
            4'hA: lit = 7'b1110111;
            4'hB: lit = 7'b0011111;
            4'hC: lit = 7'b1001110;
            4'hD: lit = 7'b0111101;
            4'hE: lit = 7'b1001111;
            default: lit = 7'b1000111;
        endcase
        return ~lit;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a raw anode/segment pattern for n cycles; returns 1 time unit after the last edge.
    task automatic drive(input logic [7:0] an, input logic [6:0] seg, input logic dp, input int n);
        an_out   = an;
        segments = seg;
        dp_out   = dp;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input int d, input logic [3:0] nib, input int n);
        drive(~(8'(1) << d), seg_of(nib), 1'b0, n);
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst         = 1'b1;
        an_out      = 8'hFF;
        segments    = 7'h7F;
        dp_out      = 1'b0;
        frame_ready = 1'b1;
        err_clear   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(frame_valid), 32'd0);
        check("reset_value", frame_value, 32'd0);
        check("reset_errs", 32'({err_multi_anode, err_dwell, err_overrun}), 32'd0);
        rst = 1'b0;
        drive(8'hFF, 7'h7F, 1'b0, 5);

        // Clean scan of 0x1234ABCD with the digit point on digit 5.
        show(0, 4'hD, 100);
        show(1, 4'hC, 100);
        show(2, 4'hB, 100);
        show(3, 4'hA, 100);
        show(4, 4'h4, 100);
        drive(~8'h20, seg_of(4'h3), 1'b1, 100);
        show(6, 4'h2, 100);
        show(7, 4'h1, 100);
        show(0, 4'hD, 1);
        check("frame1_valid", 32'(frame_valid), 32'd1);
        check("frame1_value", frame_value, 32'h1234ABCD);
        check("frame1_dp", 32'(frame_dp), 32'h20);
        check("frame1_bad", 32'(frame_bad), 32'h00);
        check("frame1_errs", 32'({err_multi_anode, err_dwell, err_overrun}), 32'd0);
        show(0, 4'hD, 1);
        check("frame1_accepted", 32'(frame_valid), 32'd0);
        show(0, 4'hD, 98);

        // Short dwell on digit 1, then clear.
        show(1, 4'hC, 90);
        show(2, 4'hB, 1);
        check("dwell_short", 32'(err_dwell), 32'(DWELL_EN));
        show(2, 4'hB, 10);
        check("dwell_sticky", 32'(err_dwell), 32'(DWELL_EN));
        err_clear = 1'b1;
        show(2, 4'hB, 1);
        err_clear = 1'b0;
        check("dwell_cleared", 32'(err_dwell), 32'd0);
        show(2, 4'hB, 88);

        // Two anodes low for one cycle with an '8' glyph on the bus.
        drive(8'hFC, seg_of(4'h8), 1'b0, 1);
        check("multi_anode", 32'(err_multi_anode), 32'd1);
        show(3, 4'hE, 100);
        show(4, 4'hF, 100);
        show(5, 4'h0, 100);
        show(6, 4'h5, 100);
        show(7, 4'h6, 100);
        show(0, 4'hD, 1);
        check("frame2_valid", 32'(frame_valid), 32'd1);
        check("frame2_value", frame_value, 32'h650FEBCD);
        check("frame2_dp", 32'(frame_dp), 32'h00);
        show(0, 4'hD, 99);

        // Stalled consumer; digit 3 shows a blank (non-hex) pattern.
        frame_ready = 1'b0;
        show(1, 4'h1, 100);
        show(2, 4'h2, 100);
        drive(~8'h08, 7'b1111111, 1'b0, 100);
        show(4, 4'h4, 100);
        show(5, 4'h5, 100);
        show(6, 4'h6, 100);
        show(7, 4'h7, 100);
        show(0, 4'h9, 1);
        check("frame3_valid", 32'(frame_valid), 32'd1);
        check("frame3_value", frame_value, 32'h7654021D);
        check("frame3_bad", 32'(frame_bad), 32'h08);
        show(0, 4'h9, 99);
        show(1, 4'hE, 100);
        show(2, 4'hD, 100);
        show(3, 4'hC, 100);
        show(4, 4'hB, 100);
        check("frame3_hold", frame_value, 32'h7654021D);
        show(5, 4'hA, 100);
        show(6, 4'h9, 100);
        show(7, 4'h8, 100);
        check("no_overrun_yet", 32'(err_overrun), 32'd0);
        show(0, 4'h0, 1);
        check("overrun_flag", 32'(err_overrun), 32'd1);
        check("overrun_valid", 32'(frame_valid), 32'd1);
        check("overrun_keep", frame_value, 32'h7654021D);
        check("overrun_keep_bad", 32'(frame_bad), 32'h08);
        frame_ready = 1'b1;
        show(0, 4'h0, 1);
        check("frame3_accepted", 32'(frame_valid), 32'd0);
        show(0, 4'h0, 98);

        // Reset after four digits of a new frame.
        show(1, 4'h1, 100);
        show(2, 4'h2, 100);
        show(3, 4'h3, 50);
        rst    = 1'b1;
        an_out = 8'hFF;
        #1;
        check("rst_value", frame_value, 32'd0);
        check("rst_bad", 32'(frame_bad), 32'd0);
        check("rst_errs", 32'({err_multi_anode, err_dwell, err_overrun}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        show(4, 4'h4, 100);
        show(5, 4'h3, 100);
        show(6, 4'h2, 100);
        show(7, 4'h1, 100);
        show(0, 4'hD, 1);
        check("rst_partial_discarded", 32'(frame_valid), 32'd0);
        show(0, 4'hD, 99);
        show(1, 4'hC, 100);
        show(2, 4'hB, 100);
        show(3, 4'hA, 100);
        show(4, 4'h4, 1);
        check("frame4_valid", 32'(frame_valid), 32'd1);
        check("frame4_value", frame_value, 32'h1234ABCD);
        check("frame4_bad", 32'(frame_bad), 32'h00);
        check("frame4_errs", 32'({err_multi_anode, err_dwell, err_overrun}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seven_segment_capture.md
SEVEN_SEGMENT_CAPTURE -- requirements
Module: seven_segment_capture

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of multiplexed digits (range 1..16).
REQ-002 SHALL have parameter CLK_FREQUENCY, default 100_000_000, clock rate in Hz.
REQ-003 SHALL have parameter DWELL_US, default 1000, expected per-digit dwell time; DWELL_CLOCKS = CLK_FREQUENCY/1_000_000*DWELL_US.
REQ-004 SHALL have parameter DWELL_TOL, default 2, allowed dwell deviation in clocks.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 segments  in  7  active-low segment lines, [6]=A .. [0]=G.
REQ-008 dp_out  in  1  digit point of the active digit.
REQ-009 an_out  in  NUM_DIGITS  active-low anode enables.
REQ-010 frame_ready  in  1  consumer accepts frame.
REQ-011 err_clear  in  1  clears all sticky error flags.
REQ-012 frame_valid  out  1  captured frame available.
REQ-013 frame_value  out  4*NUM_DIGITS  decoded hex value, digit i at [4i+:4].
REQ-014 frame_dp  out  NUM_DIGITS  captured digit points.
REQ-015 frame_bad  out  NUM_DIGITS  digit i pattern was not one of the 16 hex glyphs (its nibble is 0).
REQ-016 err_multi_anode, err_dwell, err_overrun  out  1 each  sticky error flags.

Function
REQ-017 SHALL implement FSM IDLE -> SCAN; IDLE until the first cycle with exactly one anode low, then SCAN until reset.
REQ-018 A sample cycle (exactly one anode i low) SHALL write hex/dp/bad of digit i into working registers and set collected[i].
REQ-019 All-high anodes (blank) SHALL capture nothing; the dwell counter keeps counting.
REQ-020 Two or more anodes low SHALL capture nothing and set err_multi_anode.
REQ-021 An anode change (an_out != an_out_d) in SCAN SHALL restart the dwell counter at 0; the first change after entering SCAN is exempt from the dwell check.
REQ-022 On a non-exempt change, dwell count outside [DWELL_CLOCKS-DWELL_TOL, DWELL_CLOCKS+DWELL_TOL] SHALL set err_dwell; the counter saturates, never wraps.
REQ-023 On an anode change with collected all-ones, the working registers SHALL transfer to the frame outputs at that same edge, and collected SHALL be reloaded with only the bit of the digit sampled in that cycle.
REQ-024 frame_valid SHALL stay high, with outputs stable, until a cycle with frame_valid && frame_ready.
REQ-025 Frame completion while frame_valid && !frame_ready SHALL drop the new frame, keep the old one, and set err_overrun.
REQ-026 Completion in the same cycle as an acceptance SHALL load the new frame with frame_valid remaining high.
REQ-027 Error flags SHALL clear one cycle after err_clear; a simultaneous set and clear SHALL leave the flag set.

Reset
REQ-028 rst SHALL asynchronously force FSM=IDLE, collected=0, dwell counter=0, an_out_d=all-ones, and frame_valid, frame_value, frame_dp, frame_bad and all error flags to 0.
REQ-029 Reset mid-frame SHALL discard the partial frame; no frame_valid until a full new frame.

Configuration
REQ-030 Macro SEVEN_SEGMENT_DWELL_CHECK_EN defined: dwell counter and err_dwell logic per REQ-021/022.
REQ-031 Macro undefined: no dwell counter is synthesised, err_dwell is tied 0; all other behaviour is unchanged.

Structure
REQ-032 Package seven_segment_pkg SHALL hold the 16 glyph constants, the FSM state enum and the DWELL_CLOCKS computation helper.
REQ-033 Sub-module seven_segment_decode (combinational: 7-bit pattern -> 4-bit hex + bad flag) SHALL be instantiated once.

Verification (NUM_DIGITS=8, DWELL_US=1 -> DWELL_CLOCKS=100, DWELL_TOL=2)
REQ-034 Scan digits 0..7 showing 0x1234ABCD, 100 clocks each, then one more change, frame_ready=1 -> frame_valid one cycle, frame_value=0x1234ABCD, no errors.
REQ-035 One digit held 90 clocks -> err_dwell=1 and stays set; pulse err_clear -> err_dwell=0 next cycle.
REQ-036 an_out=8'hFC for 1 cycle -> err_multi_anode=1; digits 0/1 not updated by that cycle.
REQ-037 frame_ready=0 across two full scans -> first frame held stable, err_overrun=1; raise frame_ready -> first value accepted.
REQ-038 Digit 3 pattern 7'b1111111 -> frame_bad=8'h08, nibble 3 = 0.
REQ-039 Assert rst after 4 digits -> all outputs 0 immediately; next frame_valid only after 8 new digits.
